// File: rtl/mypkg.sv
// Shared types for the L1 replacement controller.
//   protocol     : width of one way's MESI field
//   mesi_t       : MESI encoding (I=0, S=1, E=2, M=3)
//   ctrl_state_t : controller sequencing states
//   mesi_valid() : 1 only for S/E/M; I or any unknown bits count as invalid
package mypkg;

  localparam int protocol = 2;

  typedef enum logic [protocol-1:0] {
    I = 2'd0,
    S = 2'd1,
    E = 2'd2,
    M = 2'd3
  } mesi_t;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WB,
    RESP
  } ctrl_state_t;

  // case matching treats X/Z as a non-match, so such ways fall to invalid
  function automatic logic mesi_valid(logic [protocol-1:0] m);
    case (m)
      S, E, M: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/plru_victim.sv
// Combinational victim selection for one cache set.
//   plru_i   : ASSOC-1 tree PLRU bits (node n -> children 2n+1 lower, 2n+2 upper)
//   mesi_i   : MESI state of each way
//   victim_o : lowest-index invalid way, else the PLRU tree-walk result
module plru_victim
  import mypkg::*;
#(
  parameter int ASSOC = 8,
  parameter int WAY_W = $clog2(ASSOC)
) (
  input  logic [ASSOC-2:0]               plru_i,
  input  logic [ASSOC-1:0][protocol-1:0] mesi_i,
  output logic [WAY_W-1:0]               victim_o
);

  logic             found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] walk_way;

  always_comb begin
    int unsigned node;
    found    = 1'b0;
    inv_way  = '0;
    walk_way = '0;
    node     = 0;

    for (int unsigned w = 0; w < ASSOC; w++) begin
      if (!found && !mesi_valid(mesi_i[w])) begin
        found   = 1'b1;
        inv_way = WAY_W'(w);
      end
    end

    // bit=0 steers to the upper half, so each level contributes ~bit to the way index
    for (int unsigned l = 0; l < WAY_W; l++) begin
      walk_way[WAY_W-1-l] = ~plru_i[node];
      node = 2 * node + (plru_i[node] ? 32'd1 : 32'd2);
    end

    victim_o = found ? inv_way : walk_way;
  end

endmodule

// File: rtl/plru_replace_ctrl.sv
// Per-set tree-PLRU replacement controller for the L1 data cache.
// Accepts a lookup, resolves hit way or fill victim, runs a writeback
// handshake for Modified victims, then pulses a response and touches the
// responded way in the PLRU state of the captured set.
//   clk, rst_n             : clock, asynchronous active-low reset
//   req_valid/req_ready    : lookup handshake (ready only while idle)
//   req_set, req_hit, req_hit_way, req_mesi : lookup payload
//   wb_valid/wb_ready      : writeback handshake, wb_set/wb_way = victim
//   resp_valid             : one-cycle response, resp_way/resp_hit/resp_err
module plru_replace_ctrl
  import mypkg::*;
#(
  parameter int ASSOC = 8,
  parameter int SETS  = 16,
  parameter int SET_W = $clog2(SETS),
  parameter int WAY_W = $clog2(ASSOC)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [SET_W-1:0]              req_set,
  input  logic                          req_hit,
  input  logic [WAY_W-1:0]              req_hit_way,
  input  logic [ASSOC-1:0][protocol-1:0] req_mesi,
  output logic                          wb_valid,
  input  logic                          wb_ready,
  output logic [SET_W-1:0]              wb_set,
  output logic [WAY_W-1:0]              wb_way,
  output logic                          resp_valid,
  output logic [WAY_W-1:0]              resp_way,
  output logic                          resp_hit,
  output logic                          resp_err
);

  ctrl_state_t                   state_q, state_d;
  logic [SET_W-1:0]              set_q;
  logic                          hit_q;
  logic [WAY_W-1:0]              hit_way_q;
  logic [ASSOC-1:0][protocol-1:0] mesi_q;
  logic [WAY_W-1:0]              way_q, way_d;
  logic [SETS-1:0][ASSOC-2:0]    plru_q, plru_d;
  logic [WAY_W-1:0]              victim;
  logic                          accept;

  plru_victim #(
    .ASSOC (ASSOC),
    .WAY_W (WAY_W)
  ) u_victim (
    .plru_i   (plru_q[set_q]),
    .mesi_i   (mesi_q),
    .victim_o (victim)
  );

  always_comb begin
    int unsigned node;
    state_d = state_q;
    way_d   = way_q;
    plru_d  = plru_q;
    accept  = 1'b0;
    node    = 0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        // way_q holds the resolved way so wb_way stays stable through WB
        way_d = hit_q ? hit_way_q : victim;
        if (!hit_q && (mesi_q[victim] == M)) state_d = WB;
        else                                 state_d = RESP;
      end
      WB: begin
        if (wb_ready) state_d = RESP;
      end
      RESP: begin
        // point every node on the path away from the touched way
        for (int unsigned l = 0; l < WAY_W; l++) begin
          plru_d[set_q][node] = way_q[WAY_W-1-l];
          node = 2 * node + (way_q[WAY_W-1-l] ? 32'd2 : 32'd1);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      set_q     <= '0;
      hit_q     <= 1'b0;
      hit_way_q <= '0;
      mesi_q    <= '0;
      way_q     <= '0;
      plru_q    <= '0;
    end else begin
      state_q <= state_d;
      way_q   <= way_d;
      plru_q  <= plru_d;
      if (accept) begin
        set_q     <= req_set;
        hit_q     <= req_hit;
        hit_way_q <= req_hit_way;
        mesi_q    <= req_mesi;
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign wb_valid   = (state_q == WB);
  assign wb_set     = set_q;
  assign wb_way     = way_q;
  assign resp_valid = (state_q == RESP);
  assign resp_way   = resp_valid ? way_q : '0;
  assign resp_hit   = resp_valid & hit_q;
  assign resp_err   = resp_valid & hit_q & ~mesi_valid(mesi_q[hit_way_q]);

endmodule
